// File: rtl/nn_pkg.sv
// Shared types and constants for the inference controller, its MAC unit and the Avalon slave.
package nn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } nn_state_e;

   localparam int PIXEL_W     = 16;
   localparam int WEIGHT_W    = 32;
   localparam int RESULT_W    = 17;
   localparam int ACC_W       = 42;
   localparam int NUM_PAIRS   = 392;
   localparam int NUM_OUTPUTS = 10;

   // Slave word offset of result register 0; results occupy consecutive words after it.
   localparam int RESULT_REG_BASE = 4;

   function automatic int result_reg_offset(input int idx);
      return RESULT_REG_BASE + idx;
   endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Dual signed multiply-accumulate with a 42-bit accumulator and a shifted, saturated
// 17-bit view of the accumulator including the products being added this cycle.
module nn_mac_unit import nn_pkg::*; #(
   parameter int SHIFT = 8
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       acc_en,
   input  logic                       acc_clr,
   input  logic signed [PIXEL_W-1:0]  pixel1,
   input  logic signed [PIXEL_W-1:0]  pixel2,
   input  logic [WEIGHT_W-1:0]        weight,
   output logic signed [RESULT_W-1:0] result,
   output logic                       sat
);

   localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((2 ** (RESULT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(-(2 ** (RESULT_W - 1)));

   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [ACC_W-1:0]   acc_sum, acc_view, shifted;
   logic signed [PIXEL_W-1:0] w_lo, w_hi;
   logic signed [31:0]        prod_lo, prod_hi;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [31:0] v);
      return {{(ACC_W - 32){v[31]}}, v};
   endfunction

   function automatic logic is_clamped(input logic signed [ACC_W-1:0] v);
      return (v > RES_MAX) || (v < RES_MIN);
   endfunction

   function automatic logic signed [RESULT_W-1:0] sat17(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] c;
      if (v > RES_MAX)      c = RES_MAX;
      else if (v < RES_MIN) c = RES_MIN;
      else                  c = v;
      return c[RESULT_W-1:0];
   endfunction

   // Products, next accumulator and the result as it stands once this cycle's pair is added.
   always_comb begin
      w_lo     = weight[PIXEL_W-1:0];
      w_hi     = weight[WEIGHT_W-1:PIXEL_W];
      prod_lo  = pixel1 * w_lo;
      prod_hi  = pixel2 * w_hi;
      acc_sum  = acc_q + sext_prod(prod_lo) + sext_prod(prod_hi);
      acc_view = acc_en ? acc_sum : acc_q;
      if (acc_clr)     acc_d = '0;
      else if (acc_en) acc_d = acc_sum;
      else             acc_d = acc_q;
      // Arithmetic shift of a signed value floors toward minus infinity.
      shifted  = acc_view >>> SHIFT;
      result   = sat17(shifted);
      sat      = is_clamped(shifted);
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) acc_q <= '0;
      else        acc_q <= acc_d;
   end

endmodule

// File: rtl/nn_calc_controller.sv
// Inference sequencer: streams pixel pairs against each neuron's weight words through
// the MAC and posts one saturated result per output neuron to the slave.
module nn_calc_controller #(
   parameter int NUM_PAIRS   = nn_pkg::NUM_PAIRS,
   parameter int NUM_OUTPUTS = nn_pkg::NUM_OUTPUTS,
   parameter int SHIFT       = 8
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start_calc,
   input  logic               clear_data,
   output logic [9:0]         pixel_address1,
   output logic [9:0]         pixel_address2,
   input  logic signed [15:0] pixel_data1,
   input  logic signed [15:0] pixel_data2,
   output logic [11:0]        weight_address,
   input  logic [31:0]        weight_data,
   output logic [16:0]        result_output,
   output logic [3:0]         output_address,
   output logic               result_write,
   output logic               busy,
   output logic               done_calc,
   output logic               overflow
);
   import nn_pkg::*;

   localparam logic [9:0] LAST_PAIR = 10'(NUM_PAIRS - 1);
   localparam logic [3:0] LAST_OUT  = 4'(NUM_OUTPUTS - 1);

   nn_state_e   state_q, state_d;
   logic [9:0]  p_q, p_d;
   logic [3:0]  o_q, o_d;
   logic [11:0] weight_address_q, weight_address_d;
   logic [9:0]  pixel_address1_q, pixel_address1_d;
   logic [9:0]  pixel_address2_q, pixel_address2_d;
   logic [16:0] result_output_q, result_output_d;
   logic [3:0]  output_address_q, output_address_d;
   logic        result_write_q, result_write_d;
   logic        busy_q, busy_d;
   logic        done_calc_q, done_calc_d;
   logic        overflow_q, overflow_d;
   logic        acc_en, acc_clr, issue, restart;
   logic signed [RESULT_W-1:0] mac_result;
   logic        mac_sat;

   nn_mac_unit #(.SHIFT(SHIFT)) u_mac (
      .clk     (clk),
      .n_rst   (n_rst),
      .acc_en  (acc_en),
      .acc_clr (acc_clr),
      .pixel1  (pixel_data1),
      .pixel2  (pixel_data2),
      .weight  (weight_data),
      .result  (mac_result),
      .sat     (mac_sat)
   );

   // Next-state, counter and output-register computation; clear_data overrides everything.
   always_comb begin
      state_d          = state_q;
      p_d              = p_q;
      o_d              = o_q;
      weight_address_d = weight_address_q;
      pixel_address1_d = pixel_address1_q;
      pixel_address2_d = pixel_address2_q;
      result_output_d  = result_output_q;
      output_address_d = output_address_q;
      result_write_d   = 1'b0;
      overflow_d       = overflow_q;
      acc_en           = 1'b0;
      acc_clr          = 1'b0;
      issue            = 1'b0;
      restart          = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            acc_clr = 1'b1;
            if (start_calc) begin
               state_d    = ST_RUN;
               p_d        = '0;
               o_d        = '0;
               overflow_d = 1'b0;
               issue      = 1'b1;
               restart    = 1'b1;
            end
         end
         ST_RUN: begin
            // Data for pair p-1 arrives now, one cycle behind its address.
            acc_en = (p_q != '0);
            if (p_q == LAST_PAIR) begin
               state_d = ST_DRAIN;
            end else begin
               p_d   = p_q + 10'd1;
               issue = 1'b1;
            end
         end
         ST_DRAIN: begin
            // Last pair is added this cycle; the MAC result already includes it.
            acc_en           = 1'b1;
            state_d          = ST_WRITE;
            result_write_d   = 1'b1;
            result_output_d  = mac_result;
            output_address_d = o_q;
            overflow_d       = overflow_q | mac_sat;
         end
         ST_WRITE: begin
            acc_clr = 1'b1;
            p_d     = '0;
            if (o_q == LAST_OUT) begin
               state_d = ST_DONE;
            end else begin
               o_d     = o_q + 4'd1;
               state_d = ST_RUN;
               issue   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Weight index is a running counter so it stays contiguous across neurons.
      if (issue) begin
         pixel_address1_d = {p_d[8:0], 1'b0};
         pixel_address2_d = {p_d[8:0], 1'b1};
         weight_address_d = restart ? 12'd0 : weight_address_q + 12'd1;
      end

      if (clear_data) begin
         state_d          = ST_IDLE;
         p_d              = '0;
         o_d              = '0;
         weight_address_d = '0;
         pixel_address1_d = '0;
         pixel_address2_d = '0;
         result_write_d   = 1'b0;
         overflow_d       = 1'b0;
         acc_en           = 1'b0;
         acc_clr          = 1'b1;
      end

      busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_WRITE);
      done_calc_d = (state_d == ST_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q          <= ST_IDLE;
         p_q              <= '0;
         o_q              <= '0;
         weight_address_q <= '0;
         pixel_address1_q <= '0;
         pixel_address2_q <= '0;
         result_output_q  <= '0;
         output_address_q <= '0;
         result_write_q   <= 1'b0;
         busy_q           <= 1'b0;
         done_calc_q      <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         p_q              <= p_d;
         o_q              <= o_d;
         weight_address_q <= weight_address_d;
         pixel_address1_q <= pixel_address1_d;
         pixel_address2_q <= pixel_address2_d;
         result_output_q  <= result_output_d;
         output_address_q <= output_address_d;
         result_write_q   <= result_write_d;
         busy_q           <= busy_d;
         done_calc_q      <= done_calc_d;
         overflow_q       <= overflow_d;
      end
   end

   assign pixel_address1 = pixel_address1_q;
   assign pixel_address2 = pixel_address2_q;
   assign weight_address = weight_address_q;
   assign result_output  = result_output_q;
   assign output_address = output_address_q;
   assign result_write   = result_write_q;
   assign busy           = busy_q;
   assign done_calc      = done_calc_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_nn_calc_controller.sv
// Bench for nn_calc_controller: behavioural pixel/weight RAMs, a per-pixel dot-product
// reference model, and a strobe recorder; directed passes with constant and random data.
module tb_nn_calc_controller;

   localparam int NP   = 392;
   localparam int NO   = 10;
   localparam int NPIX = 2 * NP;
   localparam int NW   = NP * NO;
   localparam int PER  = NP + 2;

   logic               clk = 1'b0;
   logic               n_rst = 1'b0;
   logic               start_calc = 1'b0;
   logic               clear_data = 1'b0;
   logic [9:0]         pixel_address1, pixel_address2;
   logic signed [15:0] pixel_data1 = '0;
   logic signed [15:0] pixel_data2 = '0;
   logic [11:0]        weight_address;
   logic [31:0]        weight_data = '0;
   logic [16:0]        result_output;
   logic [3:0]         output_address;
   logic               result_write, busy, done_calc, overflow;

   shortint pix [NPIX];
   shortint wlo [NW];
   shortint whi [NW];
   int      exp_res [NO];

   int checks    = 0;
   int failures  = 0;
   int edge_n    = 0;
   int start_ref = 0;

   typedef struct {
      int cyc;
      int addr;
      int res;
      bit ovf;
   } wr_t;
   wr_t wq [$];

   nn_calc_controller #(.NUM_PAIRS(NP), .NUM_OUTPUTS(NO), .SHIFT(8)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .start_calc     (start_calc),
      .clear_data     (clear_data),
      .pixel_address1 (pixel_address1),
      .pixel_address2 (pixel_address2),
      .pixel_data1    (pixel_data1),
      .pixel_data2    (pixel_data2),
      .weight_address (weight_address),
      .weight_data    (weight_data),
      .result_output  (result_output),
      .output_address (output_address),
      .result_write   (result_write),
      .busy           (busy),
      .done_calc      (done_calc),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic signed [15:0] rd_pix(input int a);
      if (a < NPIX) return pix[a];
      return 16'sd0;
   endfunction

   function automatic logic [31:0] rd_w(input int a);
      if (a < NW) return {whi[a], wlo[a]};
      return 32'h0;
   endfunction

   // Synchronous-read RAMs: data appears one cycle after the address.
   always @(posedge clk) begin
      pixel_data1 <= rd_pix(int'(pixel_address1));
      pixel_data2 <= rd_pix(int'(pixel_address2));
      weight_data <= rd_w(int'(weight_address));
   end

   // Record every result strobe with its cycle number relative to the start edge.
   always @(negedge clk) begin
      if (result_write === 1'b1)
         wq.push_back('{edge_n - start_ref, int'(output_address),
                        int'($signed(result_output)), overflow});
   end

   // Reference: dot product over all 784 pixels, pixel i uses half (i%2) of word o*NP+i/2.
   function automatic int ref_result(input int o);
      longint acc;
      longint sh;
      acc = 0;
      for (int i = 0; i < NPIX; i++) begin
         int     word;
         longint w;
         word = o * NP + i / 2;
         w    = (i % 2 == 0) ? longint'(wlo[word]) : longint'(whi[word]);
         acc += longint'(pix[i]) * w;
      end
      sh = acc >>> 8;
      if (sh > 65535)  return 65535;
      if (sh < -65536) return -65536;
      return int'(sh);
   endfunction

   task automatic build_model();
      for (int o = 0; o < NO; o++) exp_res[o] = ref_result(o);
   endtask

   task automatic fill_const(input shortint pv, input shortint wv);
      for (int i = 0; i < NPIX; i++) pix[i] = pv;
      for (int i = 0; i < NW; i++) begin
         wlo[i] = wv;
         whi[i] = wv;
      end
      build_model();
   endtask

   // Small pixels, weight magnitude grows per neuron so later neurons tend to saturate.
   task automatic fill_random();
      for (int i = 0; i < NPIX; i++) pix[i] = shortint'(int'($urandom_range(0, 255)) - 128);
      for (int o = 0; o < NO; o++) begin
         int r;
         r = (o < 9) ? (64 << o) : 32767;
         for (int p = 0; p < NP; p++) begin
            wlo[o * NP + p] = shortint'(int'($urandom_range(0, 2 * r)) - r);
            whi[o * NP + p] = shortint'(int'($urandom_range(0, 2 * r)) - r);
         end
      end
      build_model();
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start_calc = 1'b1;
      start_ref  = edge_n;
      wq.delete();
      @(negedge clk);
      start_calc = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      int n;
      n = 0;
      while (done_calc !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      cyc = edge_n - start_ref;
   endtask

   task automatic wait_cycle(input int c);
      int n;
      n = 0;
      while ((edge_n - start_ref) < c && n < 5000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_writes(input string pfx, input int n_exp);
      check($sformatf("%s_nwrites", pfx), wq.size(), n_exp);
      for (int k = 0; k < wq.size() && k < n_exp; k++) begin
         check($sformatf("%s_cyc%0d", pfx, k), wq[k].cyc, PER * (k + 1));
         check($sformatf("%s_addr%0d", pfx, k), wq[k].addr, k);
         check($sformatf("%s_res%0d", pfx, k), wq[k].res, exp_res[k]);
      end
   endtask

   initial begin
      int dc;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_write", int'(result_write), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done_calc), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_paddr1", int'(pixel_address1), 0);
      check("rst_paddr2", int'(pixel_address2), 0);
      check("rst_waddr", int'(weight_address), 0);
      check("rst_result", int'(result_output), 0);
      check("rst_oaddr", int'(output_address), 0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // Ones, with a start pulse in RUN that must be ignored
      fill_const(16'sd1, 16'sd1);
      pulse_start();
      check("ones_busy", int'(busy), 1);
      check("ones_paddr2_first", int'(pixel_address2), 1);
      wait_cycle(100);
      start_calc = 1'b1;
      @(negedge clk);
      start_calc = 1'b0;
      wait_done(dc);
      check("ones_done_cyc", dc, PER * NO + 1);
      check_writes("ones", NO);
      if (wq.size() > 0) check("ones_lit", wq[0].res, 3);
      check("ones_ovf", int'(overflow), 0);
      check("ones_last_waddr", int'(weight_address), NW - 1);
      check("ones_last_paddr2", int'(pixel_address2), NPIX - 1);
      check("ones_busy_done", int'(busy), 0);

      // Negative weights, started from DONE
      fill_const(16'sd1, -16'sd20);
      pulse_start();
      check("neg_done_drop", int'(done_calc), 0);
      wait_done(dc);
      check("neg_done_cyc", dc, PER * NO + 1);
      check_writes("neg", NO);
      if (wq.size() > 0) check("neg_lit", wq[0].res, -62);
      check("neg_ovf", int'(overflow), 0);

      // Full-scale positive: every result clamps
      fill_const(16'sd32767, 16'sd32767);
      pulse_start();
      wait_done(dc);
      check_writes("max", NO);
      if (wq.size() > 0) begin
         check("max_lit", wq[0].res, 65535);
         check("max_ovf_first", int'(wq[0].ovf), 1);
      end
      check("max_ovf_done", int'(overflow), 1);

      // Random data; start from DONE clears overflow and done
      fill_random();
      pulse_start();
      check("rnd_done_drop", int'(done_calc), 0);
      check("rnd_ovf_clr", int'(overflow), 0);
      check("rnd_busy", int'(busy), 1);
      wait_done(dc);
      check("rnd_done_cyc", dc, PER * NO + 1);
      check_writes("rnd", NO);

      // clear_data during output 4, then restart
      fill_random();
      pulse_start();
      wait_cycle(1700);
      clear_data = 1'b1;
      @(negedge clk);
      clear_data = 1'b0;
      check("clr_busy", int'(busy), 0);
      check("clr_done", int'(done_calc), 0);
      check("clr_ovf", int'(overflow), 0);
      repeat (2500) @(negedge clk);
      check_writes("clr", 4);
      check("clr_idle_done", int'(done_calc), 0);
      pulse_start();
      wait_done(dc);
      check("restart_done_cyc", dc, PER * NO + 1);
      check_writes("restart", NO);

      // Asynchronous reset mid-pass
      pulse_start();
      wait_cycle(1000);
      n_rst = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_write", int'(result_write), 0);
      check("arst_result", int'(result_output), 0);
      check("arst_oaddr", int'(output_address), 0);
      check("arst_waddr", int'(weight_address), 0);
      check("arst_paddr1", int'(pixel_address1), 0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (600) @(negedge clk);
      check("arst_nwrites", wq.size(), 2);
      check("arst_busy_after", int'(busy), 0);
      check("arst_done_after", int'(done_calc), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
